multi_button_debouncer: RTL and testbench
=========================================

# multi_button_debouncer

Parametrised N-channel push-button debouncer: the next generation of the single-button debouncer. It replaces the one-flop slow-clock sampler with a synchronizer, a shared tick prescaler and per-channel stability counters. It also adds optional input inversion, registered press/release edge pulses and a long-press (hold) pulse per channel. It sits between the board's button pins and the user-logic domain, running entirely on the fast system clock; no derived clocks are generated.

## Interface
- N_CH, 4, number of independent button channels (1..32)
- TICK_DIV, 100000, system-clock cycles per sample tick (≥2)
- STABLE_TICKS, 8, consecutive mismatching ticks required to commit a new level (≥1)
- HOLD_TICKS, 0, ticks of continuous pressed level before o_hold fires; 0 disables hold
- ACTIVE_LOW, 0, 1 = pins read 0 when pressed (input inverted after synchronizer)

- i_clk  in  1  system clock, all logic on rising edge
- i_rst  in  1  synchronous, active-high reset
- i_btn  in  N_CH  raw asynchronous button pins
- o_level  out  N_CH  debounced pressed level (1 = pressed)
- o_press  out  N_CH  one-cycle pulse on committed 0→1
- o_release  out  N_CH  one-cycle pulse on committed 1→0
- o_hold  out  N_CH  one-cycle pulse when pressed for HOLD_TICKS ticks
- o_tick  out  1  prescaler tick strobe (for other debouncers/scanners)

## Operation
- Synchronizer: 2 flops per channel; ACTIVE_LOW inversion applied to stage-2 output → `s[i]`.
- Prescaler: counter 0..TICK_DIV-1, wraps; `o_tick`=1 in the cycle count==TICK_DIV-1. Shared by all channels.
- Per-channel FSM (states STABLE, PENDING):
  - STABLE: `s==o_level`, cnt=0. If `s!=o_level` → PENDING (no count change until a tick).
  - PENDING: any cycle with `s==o_level` → STABLE, cnt←0 (bounce aborts). On tick with `s!=o_level`: if cnt==STABLE_TICKS-1 → commit `o_level←s`, cnt←0, pulse press/release, → STABLE; else cnt←cnt+1.
- Hold: hold counter cleared while o_level=0 and on commit. On tick while o_level=1, it increments, saturating at HOLD_TICKS. o_hold pulses once, in the tick cycle it reaches HOLD_TICKS. Re-arms only after release. HOLD_TICKS=0: o_hold tied 0, counter removed.
- Widths: cnt = $clog2(STABLE_TICKS+1), hold = $clog2(HOLD_TICKS+1), prescaler = $clog2(TICK_DIV); no overflow possible.
- Channels fully independent; simultaneous commits on several channels allowed in the same cycle.

## Timing
- Reset (i_rst=1 at edge): synchronizer flops, prescaler, cnt, hold, FSM→STABLE all cleared. o_level=0, o_press=0, o_release=0, o_hold=0, o_tick=0 from the next cycle. This applies mid-PENDING or mid-hold too. With ACTIVE_LOW=1 and pins idle high, no spurious press after reset.
- Input step at cycle 0 (clean): s changes at cycle 2. Commit occurs on the STABLE_TICKS-th tick after that. Latency is between 2+(STABLE_TICKS-1)·TICK_DIV+1 and 2+STABLE_TICKS·TICK_DIV cycles.
- o_press/o_release assert in the same cycle o_level changes (all registered), for exactly one cycle.
- Commit and o_hold can never coincide (hold cleared on commit).
- o_level toggles at most once per TICK_DIV cycles per channel.

## Structure
- Package `debounce_pkg`: channel state enum {STABLE, PENDING}, width helper function, constant for synchronizer depth (2).
- Sub-module `debounce_channel`: one channel's synchronizer, FSM, cnt, hold and pulse registers. It takes tick as input and is instantiated N_CH times via generate. The prescaler lives in the top.

## Test plan
- N_CH=2, TICK_DIV=4, STABLE_TICKS=3: clean press on ch0 at cycle 10 → o_level[0] rises within cycles 21..24 with o_press[0] for 1 cycle. ch1 stays 0.
- Same params: ch0 pulses high 5 cycles then low repeatedly (bounce < 3 ticks) → no o_press, o_level[0] stays 0. Then a steady high → commit after the full 3-tick window.
- HOLD_TICKS=5: hold press 40 cycles → exactly one o_hold, 5 ticks after commit. Release → o_release, then re-press → o_hold fires again.
- ACTIVE_LOW=1, pins held 1 through reset → all outputs 0. Pin 0 driven low → o_press[0].
- Assert i_rst while ch0 PENDING with cnt=2 → all outputs 0 next cycle. After release of reset, a full 3 ticks plus 2 sync cycles are needed to commit.
- Both channels pressed on the same cycle → o_press[1:0]=2'b11 in the same cycle.

Source files
------------

// File: rtl/debounce_pkg.sv
// Shared definitions for the multi-channel push-button debouncer.
//   ch_state_e : per-channel debounce state
//   SyncStages : depth of the input synchronizer
//   width_for  : counter width able to hold values 0..max_val (at least 1 bit)
package debounce_pkg;

    typedef enum logic {
        StStable,
        StPending
    } ch_state_e;

    localparam int unsigned SyncStages = 2;

    function automatic int unsigned width_for(input int unsigned max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/debounce_channel.sv
// One debounced button channel: synchronizer, stability FSM, hold counter and
// registered event pulses. The sample tick comes from a shared prescaler.
//   clk, rst      : system clock, synchronous active-high reset
//   btn           : raw asynchronous pin
//   tick          : sample strobe, one cycle wide
//   level         : debounced pressed level (1 = pressed)
//   press_pulse   : one-cycle pulse on committed 0->1
//   release_pulse : one-cycle pulse on committed 1->0
//   hold_pulse    : one-cycle pulse after HOLD_TICKS ticks of pressed level
module debounce_channel
    import debounce_pkg::*;
#(
    parameter int unsigned STABLE_TICKS = 8,
    parameter int unsigned HOLD_TICKS   = 0,
    parameter bit          ACTIVE_LOW   = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    input  logic tick,
    output logic level,
    output logic press_pulse,
    output logic release_pulse,
    output logic hold_pulse
);

    localparam int unsigned     CntW    = width_for(STABLE_TICKS);
    localparam logic [CntW-1:0] CntLast = CntW'(STABLE_TICKS - 1);

    // Synchronizer resets to the idle pin level so an active-low pin held high
    // through reset never looks like a press.
    localparam logic IdlePin = ACTIVE_LOW;

    logic [SyncStages-1:0] sync_q;
    logic                  s;

    ch_state_e       state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            level_q, level_d;
    logic            press_q, press_d;
    logic            release_q, release_d;
    logic            commit;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= {SyncStages{IdlePin}};
        end else begin
            sync_q <= {sync_q[SyncStages-2:0], btn};
        end
    end

    assign s = sync_q[SyncStages-1] ^ ACTIVE_LOW;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        level_d = level_q;
        commit  = 1'b0;
        unique case (state_q)
            StStable: begin
                cnt_d = '0;
                if (s != level_q) begin
                    state_d = StPending;
                end
            end
            StPending: begin
                if (s == level_q) begin
                    // Bounce back to the committed level aborts the window.
                    state_d = StStable;
                    cnt_d   = '0;
                end else if (tick) begin
                    if (cnt_q == CntLast) begin
                        commit  = 1'b1;
                        level_d = s;
                        cnt_d   = '0;
                        state_d = StStable;
                    end else begin
                        cnt_d = cnt_q + CntW'(1);
                    end
                end
            end
            default: begin
                state_d = StStable;
                cnt_d   = '0;
            end
        endcase
    end

    assign press_d   = commit & s;
    assign release_d = commit & ~s;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StStable;
            cnt_q     <= '0;
            level_q   <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            level_q   <= level_d;
            press_q   <= press_d;
            release_q <= release_d;
        end
    end

    assign level         = level_q;
    assign press_pulse   = press_q;
    assign release_pulse = release_q;

    if (HOLD_TICKS > 0) begin : g_hold
        localparam int unsigned      HoldW   = width_for(HOLD_TICKS);
        localparam logic [HoldW-1:0] HoldMax = HoldW'(HOLD_TICKS);

        logic [HoldW-1:0] hold_cnt_q, hold_cnt_d;
        logic             hold_q, hold_d;

        // Saturating at HoldMax means the pulse fires once per press.
        always_comb begin
            hold_cnt_d = hold_cnt_q;
            hold_d     = 1'b0;
            if (commit || !level_q) begin
                hold_cnt_d = '0;
            end else if (tick && (hold_cnt_q != HoldMax)) begin
                hold_cnt_d = hold_cnt_q + HoldW'(1);
                hold_d     = (hold_cnt_q == HoldMax - HoldW'(1));
            end
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                hold_cnt_q <= '0;
                hold_q     <= 1'b0;
            end else begin
                hold_cnt_q <= hold_cnt_d;
                hold_q     <= hold_d;
            end
        end

        assign hold_pulse = hold_q;
    end else begin : g_no_hold
        assign hold_pulse = 1'b0;
    end

endmodule

// File: rtl/multi_button_debouncer.sv
// N-channel push-button debouncer running on the system clock. A shared
// prescaler produces the sample tick; each channel debounces independently.
//   i_clk, i_rst : system clock, synchronous active-high reset
//   i_btn        : raw asynchronous button pins
//   o_level      : debounced pressed levels (1 = pressed)
//   o_press      : one-cycle pulses on committed 0->1
//   o_release    : one-cycle pulses on committed 1->0
//   o_hold       : one-cycle pulses after HOLD_TICKS ticks pressed
//   o_tick       : prescaler tick strobe
module multi_button_debouncer
    import debounce_pkg::*;
#(
    parameter int unsigned N_CH         = 4,
    parameter int unsigned TICK_DIV     = 100000,
    parameter int unsigned STABLE_TICKS = 8,
    parameter int unsigned HOLD_TICKS   = 0,
    parameter bit          ACTIVE_LOW   = 1'b0
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic [N_CH-1:0] i_btn,
    output logic [N_CH-1:0] o_level,
    output logic [N_CH-1:0] o_press,
    output logic [N_CH-1:0] o_release,
    output logic [N_CH-1:0] o_hold,
    output logic            o_tick
);

    localparam int unsigned     DivW    = width_for(TICK_DIV - 1);
    localparam logic [DivW-1:0] DivLast = DivW'(TICK_DIV - 1);

    logic [DivW-1:0] div_q;
    logic            tick;

    assign tick = (div_q == DivLast);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            div_q <= '0;
        end else if (tick) begin
            div_q <= '0;
        end else begin
            div_q <= div_q + DivW'(1);
        end
    end

    assign o_tick = tick;

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        debounce_channel #(
            .STABLE_TICKS (STABLE_TICKS),
            .HOLD_TICKS   (HOLD_TICKS),
            .ACTIVE_LOW   (ACTIVE_LOW)
        ) u_ch (
            .clk           (i_clk),
            .rst           (i_rst),
            .btn           (i_btn[i]),
            .tick          (tick),
            .level         (o_level[i]),
            .press_pulse   (o_press[i]),
            .release_pulse (o_release[i]),
            .hold_pulse    (o_hold[i])
        );
    end

endmodule

// File: tb/tb_multi_button_debouncer.sv
// Bench for multi_button_debouncer: two instances share clock and reset.
//   dut_a: active-high pins, hold after 5 ticks
//   dut_b: active-low pins, hold disabled
// Outputs are compared every cycle against a reference model that works from
// pin history and tick arithmetic.
module tb_multi_button_debouncer;

    localparam int N_CH = 2;
    localparam int TD   = 4;
    localparam int ST   = 3;
    localparam int HA   = 5;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [N_CH-1:0] btn_a = '0;
    logic [N_CH-1:0] btn_b = '1;

    logic [N_CH-1:0] level_a, press_a, release_a, hold_a;
    logic [N_CH-1:0] level_b, press_b, release_b, hold_b;
    logic            tick_a, tick_b;

    always #5 clk = ~clk;

    multi_button_debouncer #(
        .N_CH         (N_CH),
        .TICK_DIV     (TD),
        .STABLE_TICKS (ST),
        .HOLD_TICKS   (HA),
        .ACTIVE_LOW   (1'b0)
    ) dut_a (
        .i_clk     (clk),
        .i_rst     (rst),
        .i_btn     (btn_a),
        .o_level   (level_a),
        .o_press   (press_a),
        .o_release (release_a),
        .o_hold    (hold_a),
        .o_tick    (tick_a)
    );

    multi_button_debouncer #(
        .N_CH         (N_CH),
        .TICK_DIV     (TD),
        .STABLE_TICKS (ST),
        .HOLD_TICKS   (0),
        .ACTIVE_LOW   (1'b1)
    ) dut_b (
        .i_clk     (clk),
        .i_rst     (rst),
        .i_btn     (btn_b),
        .o_level   (level_b),
        .o_press   (press_b),
        .o_release (release_b),
        .o_hold    (hold_b),
        .o_tick    (tick_b)
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference model. Cycle index k counts cycles since reset; a tick occurs
    // in every cycle with k % TD == TD-1. A new level is committed in the
    // tick cycle that completes ST ticks strictly after the cycle where the
    // synchronized input first differed, provided it has differed since.
    int              m_k;
    logic [N_CH-1:0] hist1 [2];
    logic [N_CH-1:0] hist2 [2];
    logic [N_CH-1:0] m_level [2];
    logic [N_CH-1:0] m_diff [2];
    logic [N_CH-1:0] e_press [2];
    logic [N_CH-1:0] e_rel [2];
    logic [N_CH-1:0] e_hold [2];
    int              m_dstart [2][N_CH];
    int              m_rise [2][N_CH];
    logic            e_tick;

    function automatic int ticks_in(input int a, input int b);
        // Ticks in cycles a+1 .. b inclusive.
        return (b + 1) / TD - (a + 1) / TD;
    endfunction

    task automatic model_update();
        logic tick;
        logic s;
        logic commit;
        logic [N_CH-1:0] pins;
        int hold_t;
        tick = ((m_k % TD) == TD - 1);
        if (rst) begin
            m_k = 0;
            for (int u = 0; u < 2; u++) begin
                hist1[u] = '0; hist2[u] = '0; m_level[u] = '0; m_diff[u] = '0;
                e_press[u] = '0; e_rel[u] = '0; e_hold[u] = '0;
            end
            e_tick = 1'b0;
            return;
        end
        for (int u = 0; u < 2; u++) begin
            hold_t = (u == 0) ? HA : 0;
            for (int c = 0; c < N_CH; c++) begin
                s = hist2[u][c];
                commit = 1'b0;
                e_hold[u][c] = 1'b0;
                if (s != m_level[u][c]) begin
                    if (!m_diff[u][c]) begin
                        m_diff[u][c] = 1'b1;
                        m_dstart[u][c] = m_k;
                    end
                    if (tick && ticks_in(m_dstart[u][c], m_k) == ST) commit = 1'b1;
                end else begin
                    m_diff[u][c] = 1'b0;
                end
                if (hold_t > 0 && m_level[u][c] && !commit && tick &&
                    ticks_in(m_rise[u][c] - 1, m_k) == hold_t) begin
                    e_hold[u][c] = 1'b1;
                end
                e_press[u][c] = commit && !m_level[u][c];
                e_rel[u][c]   = commit && m_level[u][c];
                if (commit) begin
                    m_level[u][c] = ~m_level[u][c];
                    m_diff[u][c]  = 1'b0;
                    if (m_level[u][c]) m_rise[u][c] = m_k + 1;
                end
            end
            pins = (u == 0) ? btn_a : ~btn_b;
            hist2[u] = hist1[u];
            hist1[u] = pins;
        end
        m_k++;
        e_tick = ((m_k % TD) == TD - 1);
    endtask

    task automatic cycle();
        @(posedge clk);
        model_update();
        #1;
        check_eq("a_level", level_a, m_level[0]);
        check_eq("a_press", press_a, e_press[0]);
        check_eq("a_release", release_a, e_rel[0]);
        check_eq("a_hold", hold_a, e_hold[0]);
        check_eq("a_tick", tick_a, e_tick);
        check_eq("b_level", level_b, m_level[1]);
        check_eq("b_press", press_b, e_press[1]);
        check_eq("b_release", release_b, e_rel[1]);
        check_eq("b_hold", hold_b, e_hold[1]);
        check_eq("b_tick", tick_b, e_tick);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    // Drive a logical pressed pattern onto both instances.
    task automatic drive(input logic [N_CH-1:0] pressed);
        btn_a = pressed;
        btn_b = ~pressed;
    endtask

    initial begin
        int hold_a0;
        m_k = 0;
        // Reset with active-low pins idle high.
        rst = 1'b1;
        drive(2'b00);
        run(3);
        rst = 1'b0;
        run(10);

        // Clean press on ch0, long enough for hold; release; re-press.
        drive(2'b01);
        run(40);
        drive(2'b00);
        run(20);
        drive(2'b01);
        hold_a0 = 0;
        for (int i = 0; i < 40; i++) begin
            cycle();
            if (hold_a[0]) hold_a0++;
        end
        check_eq("a_hold_once", hold_a0, 1);
        drive(2'b00);
        run(20);

        // Bounce shorter than the stability window, then a steady press.
        for (int r = 0; r < 4; r++) begin
            drive(2'b01);
            run(5);
            drive(2'b00);
            run(5);
        end
        check_eq("bounce_level", level_a[0], 1'b0);
        drive(2'b01);
        run(30);
        drive(2'b00);
        run(30);

        // Simultaneous press on both channels.
        drive(2'b11);
        run(30);
        drive(2'b00);
        run(30);

        // Reset while ch0 is mid-window, pin kept pressed.
        drive(2'b01);
        run(11);
        rst = 1'b1;
        run(1);
        rst = 1'b0;
        run(30);
        drive(2'b00);
        run(30);

        // Randomized pin activity with occasional resets.
        for (int seg = 0; seg < 120; seg++) begin
            drive(2'($urandom_range(0, 3)));
            if ($urandom_range(0, 24) == 0) begin
                rst = 1'b1;
                run($urandom_range(1, 2));
                rst = 1'b0;
            end
            run($urandom_range(1, 18));
        end
        drive(2'b00);
        run(30);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
